// File: rtl/padding_loop_ctrl_if.sv
// Sequencer <-> Compute_Cluster_Mem bundle: start/end handshake plus chunk read/write controls.
// Field widths follow clog2 of the sequencer's write-cycle, SRAM-slot and buffer counts.
interface padding_loop_ctrl_if #(
  parameter int WC_W  = 2,
  parameter int IFM_W = 8,
  parameter int FIL_W = 6,
  parameter int OB_W  = 4
);
  logic             start_i;
  logic             total_chunk_end_i;
  logic             run_valid_o;
  logic             total_chunk_start_o;
  logic             ifm_chunk_wr_valid_o;
  logic [WC_W-1:0]  ifm_chunk_wr_count_o;
  logic             ifm_chunk_wr_sel_o;
  logic             ifm_chunk_rd_sel_o;
  logic [IFM_W-1:0] ifm_sram_rd_count_o;
  logic             fil_chunk_wr_valid_o;
  logic [WC_W-1:0]  fil_chunk_wr_count_o;
  logic             fil_chunk_wr_sel_o;
  logic             fil_chunk_rd_sel_o;
  logic [FIL_W-1:0] fil_sram_rd_count_o;
  logic [WC_W-1:0]  rd_fil_sparsemap_last_o;
  logic [OB_W-1:0]  acc_buf_sel_o;
  logic             done_o;

  modport master (
    input  start_i, total_chunk_end_i,
    output run_valid_o, total_chunk_start_o,
           ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o, ifm_chunk_wr_sel_o, ifm_chunk_rd_sel_o,
           ifm_sram_rd_count_o,
           fil_chunk_wr_valid_o, fil_chunk_wr_count_o, fil_chunk_wr_sel_o, fil_chunk_rd_sel_o,
           fil_sram_rd_count_o, rd_fil_sparsemap_last_o, acc_buf_sel_o, done_o
  );

  modport slave (
    output start_i, total_chunk_end_i,
    input  run_valid_o, total_chunk_start_o,
           ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o, ifm_chunk_wr_sel_o, ifm_chunk_rd_sel_o,
           ifm_sram_rd_count_o,
           fil_chunk_wr_valid_o, fil_chunk_wr_count_o, fil_chunk_wr_sel_o, fil_chunk_rd_sel_o,
           fil_sram_rd_count_o, rd_fil_sparsemap_last_o, acc_buf_sel_o, done_o
  );
endinterface

// File: rtl/padding_loop_ctrl.sv
// Channel-padding loop sequencer: z/fy/fx/oy/ox walk with ping-pong chunk prefetch; bursts start
// one cycle after slot load. Stalls in WAIT_PF until prefetch lands; no backpressure on its outputs.
module padding_loop_burst #(
  parameter int AW = 8,
  parameter int CW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_launch,
  input  logic [AW-1:0] i_addr,
  input  logic [CW-1:0] i_last,
  output logic          o_wr_valid,
  output logic [CW-1:0] o_wr_count,
  output logic [AW-1:0] o_rd_count,
  output logic          o_idle_nxt
);
  logic          r_pend;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_last;
  logic [AW-1:0] r_addr;

  // Slot address lands one cycle ahead of the beats so the SRAM read lines up with beat 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_last <= '0;
      r_addr <= '0;
    end else if (i_launch) begin
      r_addr <= i_addr;
      r_last <= i_last;
      r_pend <= 1'b1;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_pend) begin
      r_pend <= 1'b0;
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == r_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_wr_valid = r_busy;
  assign o_wr_count = r_cnt;
  assign o_rd_count = r_addr;
  assign o_idle_nxt = !r_pend && (!r_busy || (r_cnt == r_last));
endmodule

module padding_loop_ctrl #(
  parameter int CH_NUM       = 20,
  parameter int CHUNK        = 16,
  parameter int BUS          = 8,
  parameter int FIL_X        = 3,
  parameter int FIL_Y        = 3,
  parameter int OUT_X        = 2,
  parameter int OUT_Y        = 2,
  parameter int WR_CYC       = 4,
  parameter int IFM_SRAM_NUM = 256,
  parameter int FIL_SRAM_NUM = 64,
  parameter int OBUF_NUM     = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  padding_loop_ctrl_if.master bus
);
  localparam int IFM_X   = OUT_X + FIL_X - 1;
  localparam int IFM_Y   = OUT_Y + FIL_Y - 1;
  localparam int ZN      = (CH_NUM + CHUNK - 1) / CHUNK;
  localparam int LAST_SZ = (CH_NUM % CHUNK == 0) ? CHUNK : (CH_NUM % CHUNK);
  localparam int WC_W    = $clog2(WR_CYC);
  localparam int IFM_W   = $clog2(IFM_SRAM_NUM);
  localparam int FIL_W   = $clog2(FIL_SRAM_NUM);
  localparam int OB_W    = $clog2(OBUF_NUM);
  localparam int ZW      = $clog2(ZN + 1);
  localparam int FYW     = $clog2(FIL_Y + 1);
  localparam int FXW     = $clog2(FIL_X + 1);
  localparam int OYW     = $clog2(OUT_Y + 1);
  localparam int OXW     = $clog2(OUT_X + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_ISSUE, S_WAIT_END, S_WAIT_PF, S_DONE
  } state_t;

  function automatic logic [WC_W-1:0] f_last_beat(input logic [ZW-1:0] z);
    int sz;
    sz = (int'(z) == ZN - 1) ? LAST_SZ : CHUNK;
    return WC_W'((sz + BUS - 1) / BUS - 1);
  endfunction

  function automatic logic [FIL_W-1:0] f_fil_addr(input logic [ZW-1:0] z,
                                                  input logic [FYW-1:0] fy,
                                                  input logic [FXW-1:0] fx);
    return FIL_W'(int'(z) * FIL_Y * FIL_X + int'(fy) * FIL_X + int'(fx));
  endfunction

  function automatic logic [IFM_W-1:0] f_ifm_addr(input logic [ZW-1:0] z,
                                                  input logic [FYW-1:0] fy,
                                                  input logic [FXW-1:0] fx,
                                                  input logic [OYW-1:0] oy,
                                                  input logic [OXW-1:0] ox);
    return IFM_W'(int'(z) * IFM_Y * IFM_X + (int'(oy) + int'(fy)) * IFM_X + int'(ox) + int'(fx));
  endfunction

  state_t          r_state, w_state_nxt;
  logic [ZW-1:0]   r_z, w_nx_z;
  logic [FYW-1:0]  r_fy, w_nx_fy;
  logic [FXW-1:0]  r_fx, w_nx_fx;
  logic [OYW-1:0]  r_oy, w_nx_oy;
  logic [OXW-1:0]  r_ox, w_nx_ox;
  logic            w_last_iter, w_nx_fil_chg;
  logic            r_last, r_fil_tog, r_run_valid;
  logic            r_ifm_rd_sel, r_fil_rd_sel;
  logic [OB_W-1:0] r_acc;
  logic [WC_W-1:0] r_spm_last;
  logic            w_ifm_launch, w_fil_launch;
  logic [IFM_W-1:0] w_ifm_addr;
  logic [FIL_W-1:0] w_fil_addr;
  logic [WC_W-1:0] w_pf_last;
  logic            w_ifm_idle, w_fil_idle, w_pf_idle;

  // Successor of the iteration held in r_*: ox fastest, then oy, fx, fy, z.
  always_comb begin
    w_nx_z       = r_z;
    w_nx_fy      = r_fy;
    w_nx_fx      = r_fx;
    w_nx_oy      = r_oy;
    w_nx_ox      = r_ox;
    w_last_iter  = 1'b0;
    w_nx_fil_chg = (r_ox == OXW'(OUT_X - 1)) && (r_oy == OYW'(OUT_Y - 1));
    if (r_ox != OXW'(OUT_X - 1)) begin
      w_nx_ox = r_ox + OXW'(1);
    end else begin
      w_nx_ox = '0;
      if (r_oy != OYW'(OUT_Y - 1)) begin
        w_nx_oy = r_oy + OYW'(1);
      end else begin
        w_nx_oy = '0;
        if (r_fx != FXW'(FIL_X - 1)) begin
          w_nx_fx = r_fx + FXW'(1);
        end else begin
          w_nx_fx = '0;
          if (r_fy != FYW'(FIL_Y - 1)) begin
            w_nx_fy = r_fy + FYW'(1);
          end else begin
            w_nx_fy = '0;
            if (r_z != ZW'(ZN - 1)) w_nx_z = r_z + ZW'(1);
            else                    w_last_iter = 1'b1;
          end
        end
      end
    end
  end

  assign w_pf_idle = w_ifm_idle && w_fil_idle;

  always_comb begin
    w_state_nxt  = r_state;
    w_ifm_launch = 1'b0;
    w_fil_launch = 1'b0;
    w_ifm_addr   = f_ifm_addr(w_nx_z, w_nx_fy, w_nx_fx, w_nx_oy, w_nx_ox);
    w_fil_addr   = f_fil_addr(w_nx_z, w_nx_fy, w_nx_fx);
    w_pf_last    = f_last_beat(w_nx_z);
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt  = S_PRELOAD;
          w_ifm_launch = 1'b1;
          w_fil_launch = 1'b1;
          w_ifm_addr   = '0;
          w_fil_addr   = '0;
          w_pf_last    = f_last_beat(ZW'(0));
        end
      end
      S_PRELOAD: if (w_pf_idle) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt = S_WAIT_END;
        if (!w_last_iter) begin
          w_ifm_launch = 1'b1;
          w_fil_launch = w_nx_fil_chg;
        end
      end
      S_WAIT_END: begin
        if (bus.total_chunk_end_i) begin
          if (r_last)         w_state_nxt = S_DONE;
          else if (w_pf_idle) w_state_nxt = S_ISSUE;
          else                w_state_nxt = S_WAIT_PF;
        end
      end
      S_WAIT_PF: if (w_pf_idle) w_state_nxt = S_ISSUE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // r_* indices step to the successor as each sub-chunk issues; r_last marks the final one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_z          <= '0;
      r_fy         <= '0;
      r_fx         <= '0;
      r_oy         <= '0;
      r_ox         <= '0;
      r_last       <= 1'b0;
      r_fil_tog    <= 1'b0;
      r_run_valid  <= 1'b0;
      r_ifm_rd_sel <= 1'b0;
      r_fil_rd_sel <= 1'b0;
      r_acc        <= '0;
      r_spm_last   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.start_i) begin
        r_z       <= '0;
        r_fy      <= '0;
        r_fx      <= '0;
        r_oy      <= '0;
        r_ox      <= '0;
        r_last    <= 1'b0;
        r_fil_tog <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_fil_tog <= w_nx_fil_chg;
        r_last    <= w_last_iter;
        if (!w_last_iter) begin
          r_z  <= w_nx_z;
          r_fy <= w_nx_fy;
          r_fx <= w_nx_fx;
          r_oy <= w_nx_oy;
          r_ox <= w_nx_ox;
        end
      end
      if (w_state_nxt == S_ISSUE) begin
        r_run_valid  <= 1'b1;
        r_acc        <= OB_W'(int'(r_oy) * OUT_X + int'(r_ox));
        r_spm_last   <= f_last_beat(r_z);
        r_ifm_rd_sel <= !r_ifm_rd_sel;
        if (r_fil_tog) r_fil_rd_sel <= !r_fil_rd_sel;
      end
      if (w_state_nxt == S_DONE) r_run_valid <= 1'b0;
    end
  end

  padding_loop_burst #(.AW(IFM_W), .CW(WC_W)) u_ifm_burst (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_launch   (w_ifm_launch),
    .i_addr     (w_ifm_addr),
    .i_last     (w_pf_last),
    .o_wr_valid (bus.ifm_chunk_wr_valid_o),
    .o_wr_count (bus.ifm_chunk_wr_count_o),
    .o_rd_count (bus.ifm_sram_rd_count_o),
    .o_idle_nxt (w_ifm_idle)
  );

  padding_loop_burst #(.AW(FIL_W), .CW(WC_W)) u_fil_burst (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_launch   (w_fil_launch),
    .i_addr     (w_fil_addr),
    .i_last     (w_pf_last),
    .o_wr_valid (bus.fil_chunk_wr_valid_o),
    .o_wr_count (bus.fil_chunk_wr_count_o),
    .o_rd_count (bus.fil_sram_rd_count_o),
    .o_idle_nxt (w_fil_idle)
  );

  assign bus.run_valid_o             = r_run_valid;
  assign bus.total_chunk_start_o     = (r_state == S_ISSUE);
  assign bus.done_o                  = (r_state == S_DONE);
  assign bus.ifm_chunk_rd_sel_o      = r_ifm_rd_sel;
  assign bus.ifm_chunk_wr_sel_o      = !r_ifm_rd_sel;
  assign bus.fil_chunk_rd_sel_o      = r_fil_rd_sel;
  assign bus.fil_chunk_wr_sel_o      = !r_fil_rd_sel;
  assign bus.acc_buf_sel_o           = r_acc;
  assign bus.rd_fil_sparsemap_last_o = r_spm_last;
endmodule

// File: tb/tb_padding_loop_ctrl.sv
// Directed bench for padding_loop_ctrl: full layer walk, WAIT_PF stalls, stray inputs, mid-run reset.
`timescale 1ns/1ps
module tb_padding_loop_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  padding_loop_ctrl_if bus();
  padding_loop_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.master));

  int   checks = 0;
  int   errors = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   s0, d0;
  logic exp_ifm_sel, exp_fil_sel;

  always @(negedge clk) begin
    if (bus.total_chunk_start_o) n_start++;
    if (bus.done_o) n_done++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Iteration i -> indices, ox fastest then oy, fx, fy, z.
  function automatic int f_z(input int i);  return i / 36;        endfunction
  function automatic int f_fy(input int i); return (i / 12) % 3;  endfunction
  function automatic int f_fx(input int i); return (i / 4) % 3;   endfunction
  function automatic int f_oy(input int i); return (i / 2) % 2;   endfunction
  function automatic int f_ox(input int i); return i % 2;         endfunction
  function automatic int fil_addr(input int i);
    return f_z(i) * 9 + f_fy(i) * 3 + f_fx(i);
  endfunction
  function automatic int ifm_addr(input int i);
    return f_z(i) * 16 + (f_oy(i) + f_fy(i)) * 4 + f_ox(i) + f_fx(i);
  endfunction

  task automatic check_reset_outputs(input string t);
    chk({t, "_run_valid"}, bus.run_valid_o, 0);
    chk({t, "_start"}, bus.total_chunk_start_o, 0);
    chk({t, "_done"}, bus.done_o, 0);
    chk({t, "_ifm_wv"}, bus.ifm_chunk_wr_valid_o, 0);
    chk({t, "_fil_wv"}, bus.fil_chunk_wr_valid_o, 0);
    chk({t, "_ifm_wc"}, bus.ifm_chunk_wr_count_o, 0);
    chk({t, "_fil_wc"}, bus.fil_chunk_wr_count_o, 0);
    chk({t, "_ifm_wsel"}, bus.ifm_chunk_wr_sel_o, 1);
    chk({t, "_fil_wsel"}, bus.fil_chunk_wr_sel_o, 1);
    chk({t, "_ifm_rsel"}, bus.ifm_chunk_rd_sel_o, 0);
    chk({t, "_fil_rsel"}, bus.fil_chunk_rd_sel_o, 0);
    chk({t, "_ifm_rc"}, bus.ifm_sram_rd_count_o, 0);
    chk({t, "_fil_rc"}, bus.fil_sram_rd_count_o, 0);
    chk({t, "_spm"}, bus.rd_fil_sparsemap_last_o, 0);
    chk({t, "_acc"}, bus.acc_buf_sel_o, 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first start pulse.
  task automatic do_preload();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("pre1_ifm_wv", bus.ifm_chunk_wr_valid_o, 0);
    chk("pre1_ifm_rc", bus.ifm_sram_rd_count_o, 0);
    chk("pre1_fil_rc", bus.fil_sram_rd_count_o, 0);
    chk("pre1_run_valid", bus.run_valid_o, 0);
    @(negedge clk);
    chk("pre2_ifm_wv", bus.ifm_chunk_wr_valid_o, 1);
    chk("pre2_fil_wv", bus.fil_chunk_wr_valid_o, 1);
    chk("pre2_ifm_wc", bus.ifm_chunk_wr_count_o, 0);
    chk("pre2_fil_wc", bus.fil_chunk_wr_count_o, 0);
    chk("pre2_ifm_wsel", bus.ifm_chunk_wr_sel_o, 1);
    @(negedge clk);
    chk("pre3_ifm_wv", bus.ifm_chunk_wr_valid_o, 1);
    chk("pre3_fil_wv", bus.fil_chunk_wr_valid_o, 1);
    chk("pre3_ifm_wc", bus.ifm_chunk_wr_count_o, 1);
    chk("pre3_fil_wc", bus.fil_chunk_wr_count_o, 1);
    chk("pre3_start", bus.total_chunk_start_o, 0);
    @(negedge clk);
    chk("pre4_start", bus.total_chunk_start_o, 1);
    chk("pre4_ifm_wv", bus.ifm_chunk_wr_valid_o, 0);
  endtask

  // Entered at the negedge of iteration i's start pulse; leaves at the next start (or done).
  task automatic run_iter(input int i, input bit fast, input bit stray);
    int gap, exp_gap, exp_n;
    bit seen;
    exp_ifm_sel = !exp_ifm_sel;
    if (i % 4 == 0) exp_fil_sel = !exp_fil_sel;
    chk($sformatf("it%0d_start", i), bus.total_chunk_start_o, 1);
    chk($sformatf("it%0d_acc", i), bus.acc_buf_sel_o, f_oy(i) * 2 + f_ox(i));
    chk($sformatf("it%0d_spm", i), bus.rd_fil_sparsemap_last_o, (f_z(i) == 0) ? 1 : 0);
    chk($sformatf("it%0d_ifm_rsel", i), bus.ifm_chunk_rd_sel_o, exp_ifm_sel);
    chk($sformatf("it%0d_fil_rsel", i), bus.fil_chunk_rd_sel_o, exp_fil_sel);
    chk($sformatf("it%0d_ifm_wsel", i), bus.ifm_chunk_wr_sel_o, !exp_ifm_sel);
    chk($sformatf("it%0d_fil_wsel", i), bus.fil_chunk_wr_sel_o, !exp_fil_sel);
    chk($sformatf("it%0d_run_valid", i), bus.run_valid_o, 1);
    if (i == 71)   exp_gap = 6;
    else if (fast) exp_gap = (f_z(i + 1) == 0) ? 4 : 3;
    else           exp_gap = 6;
    exp_n = (i < 71) ? i + 1 : i;
    seen = 1'b0;
    gap = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      bus.total_chunk_end_i = 1'b0;
      bus.start_i = 1'b0;
      if (c == 1) begin
        chk($sformatf("it%0d_ifm_rc", i), bus.ifm_sram_rd_count_o, ifm_addr(exp_n));
        chk($sformatf("it%0d_fil_rc", i), bus.fil_sram_rd_count_o, fil_addr(exp_n));
      end
      if (c == 2) begin
        chk($sformatf("it%0d_ifm_wv0", i), bus.ifm_chunk_wr_valid_o, i < 71);
        chk($sformatf("it%0d_ifm_wc0", i), bus.ifm_chunk_wr_count_o, 0);
        chk($sformatf("it%0d_fil_wv0", i), bus.fil_chunk_wr_valid_o, (i < 71) && (i % 4 == 3));
      end
      if (c == 3) begin
        chk($sformatf("it%0d_ifm_wv1", i), bus.ifm_chunk_wr_valid_o, (i < 71) && (f_z(i + 1) == 0));
      end
      if ((i == 71) ? bus.done_o : bus.total_chunk_start_o) begin
        seen = 1'b1;
        gap = c;
      end else begin
        if (fast ? (c <= 2) : (c == 5)) bus.total_chunk_end_i = 1'b1;
        if (stray && c == 2) bus.start_i = 1'b1;
      end
    end
    chk($sformatf("it%0d_next_seen", i), seen, 1);
    chk($sformatf("it%0d_gap", i), gap, exp_gap);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.total_chunk_end_i = 1'b0;
    rst_n = 1'b0;
    exp_ifm_sel = 1'b0;
    exp_fil_sel = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Stray end pulse in IDLE must not wake the sequencer.
    @(negedge clk);
    bus.total_chunk_end_i = 1'b1;
    @(negedge clk);
    bus.total_chunk_end_i = 1'b0;
    chk("idle_ifm_wv", bus.ifm_chunk_wr_valid_o, 0);
    chk("idle_start", bus.total_chunk_start_o, 0);
    @(negedge clk);
    chk("idle_run_valid", bus.run_valid_o, 0);

    s0 = n_start;
    d0 = n_done;
    do_preload();
    for (int i = 0; i < 72; i++) run_iter(i, (i == 2) || (i == 40), i == 10);
    chk("layer_done_run_valid", bus.run_valid_o, 0);
    @(negedge clk);
    chk("post_done", bus.done_o, 0);
    chk("post_start", bus.total_chunk_start_o, 0);
    chk("layer_start_count", n_start - s0, 72);
    chk("layer_done_count", n_done - d0, 1);

    // Second layer, aborted by reset while sub-chunk 5 computes and its prefetch is writing.
    d0 = n_done;
    do_preload();
    for (int i = 0; i < 5; i++) run_iter(i, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ifm_wv", bus.ifm_chunk_wr_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_done", n_done - d0, 0);
    exp_ifm_sel = 1'b0;
    exp_fil_sel = 1'b0;
    @(negedge clk);
    do_preload();
    run_iter(0, 1'b0, 1'b0);
    run_iter(1, 1'b0, 1'b0);
    chk("restart_acc2", bus.acc_buf_sel_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
